// File: rtl/opcode_pipe_tracker.sv
// Pipeline register and hazard tracker ahead of the control unit. It carries the
// opcode and register fields of each instruction from ID to WB and handles load-use bubbles, flush and halt drain.
module opcode_pipe_tracker #(
  parameter logic [3:0]  NOP_OP  = 4'b0000,
  parameter logic [3:0]  LBU_OP  = 4'b0100,
  parameter logic [3:0]  LW_OP   = 4'b1000,
  parameter logic [3:0]  HALT_OP = 4'b1111,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      InstrIn,
  input  logic             FetchValid,
  input  logic             Flush,
  output logic [3:0]       OpcodeID,
  output logic [3:0]       OpcodeEX,
  output logic [3:0]       OpcodeMEM,
  output logic [3:0]       OpcodeWB,
  output logic [3:0]       FunctionCode,
  output logic [3:0]       Op1EX,
  output logic [3:0]       Op2EX,
  output logic [3:0]       Op1WB,
  output logic             Stall,
  output logic             StopFetch,
  output logic             Done,
  output logic [CNT_W-1:0] StallCount
);

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] op1;
    logic [3:0] op2;
    logic [3:0] fn;
  } stage_t;

  // After EX only the opcode, destination and function are consumed downstream.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] op1;
    logic [3:0] fn;
  } late_t;

  localparam stage_t BUBBLE      = '{op: NOP_OP, op1: 4'd0, op2: 4'd0, fn: 4'd0};
  localparam late_t  LATE_BUBBLE = '{op: NOP_OP, op1: 4'd0, fn: 4'd0};

  stage_t            if_id_q, if_id_d;
  stage_t            id_ex_q, id_ex_d;
  late_t             ex_mem_q, ex_mem_d;
  late_t             mem_wb_q, mem_wb_d;
  logic              stop_fetch_q, stop_fetch_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              ex_is_load;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  assign ex_is_load = (id_ex_q.op == LBU_OP) || (id_ex_q.op == LW_OP);
  assign Stall      = ex_is_load && (if_id_q.op != NOP_OP) &&
                      ((id_ex_q.op1 == if_id_q.op1) || (id_ex_q.op1 == if_id_q.op2));

  always_comb begin
    if_id_d      = if_id_q;
    id_ex_d      = id_ex_q;
    ex_mem_d     = ex_mem_q;
    mem_wb_d     = mem_wb_q;
    stop_fetch_d = stop_fetch_q;
    done_d       = done_q;
    stall_cnt_d  = stall_cnt_q;

    // Stall outranks flush so a held branch re-evaluates Flush next cycle.
    if (Stall) begin
      if_id_d = if_id_q;
    end else if (Flush || stop_fetch_q || !FetchValid) begin
      if_id_d = BUBBLE;
    end else begin
      if_id_d = stage_t'(InstrIn);
    end

    id_ex_d  = Stall ? BUBBLE : if_id_q;
    ex_mem_d = '{op: id_ex_q.op, op1: id_ex_q.op1, fn: id_ex_q.fn};
    mem_wb_d = ex_mem_q;

    if ((if_id_q.op == HALT_OP) && !Stall) begin
      stop_fetch_d = 1'b1;
    end
    if (mem_wb_q.op == HALT_OP) begin
      done_d = 1'b1;
    end
    if (Stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      if_id_q      <= BUBBLE;
      id_ex_q      <= BUBBLE;
      ex_mem_q     <= LATE_BUBBLE;
      mem_wb_q     <= LATE_BUBBLE;
      stop_fetch_q <= 1'b0;
      done_q       <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      if_id_q      <= if_id_d;
      id_ex_q      <= id_ex_d;
      ex_mem_q     <= ex_mem_d;
      mem_wb_q     <= mem_wb_d;
      stop_fetch_q <= stop_fetch_d;
      done_q       <= done_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign OpcodeID     = if_id_q.op;
  assign OpcodeEX     = id_ex_q.op;
  assign Op1EX        = id_ex_q.op1;
  assign Op2EX        = id_ex_q.op2;
  assign OpcodeMEM    = ex_mem_q.op;
  assign OpcodeWB     = mem_wb_q.op;
  assign Op1WB        = mem_wb_q.op1;
  assign FunctionCode = mem_wb_q.fn;
  assign StopFetch    = stop_fetch_q;
  assign Done         = done_q;
  assign StallCount   = stall_cnt_q;

endmodule
